// File: rtl/pe_sched_pkg.sv
// Shared types and sizing for the convolution window scheduler.
// Optional PE_WINDOW_SCHED_RELU_EN (see pe_window_sched) clamps negative results.
package pe_sched_pkg;
  localparam int K      = 5;
  localparam int PIC_W  = 16;
  localparam int WGT_W  = 16;
  localparam int RES_W  = 37;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;
  localparam int KK     = K * K;
  localparam int KK_W   = $clog2(KK);
  localparam int KC_W   = $clog2(K);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    WAIT,
    OUT,
    DONE
  } state_t;
endpackage

// File: rtl/pe_sched_addr_gen.sv
// Window/kernel counters and multiplier-free pixel address generation.
// row_base tracks (y+ky)*img_w + x; win_base tracks y*img_w + x.
module pe_sched_addr_gen
  import pe_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic              adv,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [ADDR_W-1:0] pic_addr,
  output logic [KK_W-1:0]   wgt_addr,
  output logic              fetch_last,
  output logic              win_last
);
  localparam logic [KC_W-1:0]  KMAX = KC_W'(K - 1);
  localparam logic [DIM_W-1:0] KD   = DIM_W'(K);

  logic [KC_W-1:0]   kx, ky;
  logic [DIM_W-1:0]  x, y;
  logic [KK_W-1:0]   widx;
  logic [ADDR_W-1:0] win_base, row_base;
  logic              x_last, y_last;

  assign x_last     = (x == img_w - KD);
  assign y_last     = (y == img_h - KD);
  assign win_last   = x_last & y_last;
  assign fetch_last = (kx == KMAX) & (ky == KMAX);
  assign pic_addr   = row_base + ADDR_W'(kx);
  assign wgt_addr   = widx;

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      kx       <= '0;
      ky       <= '0;
      x        <= '0;
      y        <= '0;
      widx     <= '0;
      win_base <= '0;
      row_base <= '0;
    end else if (step) begin
      if (fetch_last) begin
        kx       <= '0;
        ky       <= '0;
        widx     <= '0;
        row_base <= win_base;
      end else if (kx == KMAX) begin
        kx       <= '0;
        ky       <= ky + 1'b1;
        widx     <= widx + 1'b1;
        row_base <= row_base + ADDR_W'(img_w);
      end else begin
        kx   <= kx + 1'b1;
        widx <= widx + 1'b1;
      end
    end else if (adv) begin
      // end of a row of windows: x=img_w-K, so +K lands on the next row start
      if (x_last) begin
        x        <= '0;
        y        <= y + 1'b1;
        win_base <= win_base + ADDR_W'(K);
        row_base <= win_base + ADDR_W'(K);
      end else begin
        x        <= x + 1'b1;
        win_base <= win_base + 1'b1;
        row_base <= win_base + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pe_window_sched.sv
// Walks every KxK window of an image, feeds the PE, returns results.
// Define PE_WINDOW_SCHED_RELU_EN to clamp negative results to zero.
module pe_window_sched
  import pe_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pic_rd_en,
  output logic [ADDR_W-1:0] pic_addr,
  input  logic [PIC_W-1:0]  pic_rdata,
  output logic              wgt_rd_en,
  output logic [KK_W-1:0]   wgt_addr,
  input  logic [WGT_W-1:0]  wgt_rdata,
  output logic [PIC_W-1:0]  pe_picDat,
  output logic [WGT_W-1:0]  pe_weightDat,
  output logic              pe_in_vld,
  output logic              pe_in_last,
  input  logic [RES_W-1:0]  pe_result,
  input  logic              pe_valid,
  output logic [RES_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready
);
  state_t state, nxt;

  logic [DIM_W-1:0] w_q, h_q;
  logic [RES_W-1:0] res_q, cap;
  logic             err_q, rd_q, last_q;
  logic             init, step, adv;
  logic             fetch_last, win_last, bad;

  assign bad = (w_q < DIM_W'(K)) | (h_q < DIM_W'(K));

`ifdef PE_WINDOW_SCHED_RELU_EN
  assign cap = pe_result[RES_W-1] ? '0 : pe_result;
`else
  assign cap = pe_result;
`endif

  pe_sched_addr_gen u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .step       (step),
    .adv        (adv),
    .img_w      (w_q),
    .img_h      (h_q),
    .pic_addr   (pic_addr),
    .wgt_addr   (wgt_addr),
    .fetch_last (fetch_last),
    .win_last   (win_last)
  );

  always_comb begin
    nxt  = state;
    init = 1'b0;
    step = 1'b0;
    adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt  = CHECK;
          init = 1'b1;
        end
      end
      CHECK: nxt = bad ? DONE : FETCH;
      FETCH: begin
        step = 1'b1;
        if (fetch_last) nxt = WAIT;
      end
      WAIT: if (pe_valid) nxt = OUT;
      OUT: begin
        if (res_ready) begin
          if (win_last) begin
            nxt = DONE;
          end else begin
            adv = 1'b1;
            nxt = FETCH;
          end
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy      = (state == CHECK) | (state == FETCH) |
                     (state == WAIT)  | (state == OUT);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign pic_rd_en = (state == FETCH);
  assign wgt_rd_en = (state == FETCH);
  assign res_valid = (state == OUT);
  assign res_data  = res_q;

  // rd_q/last_q line up with the SRAM data cycle; the PE sees both one later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      err_q        <= 1'b0;
      res_q        <= '0;
      rd_q         <= 1'b0;
      last_q       <= 1'b0;
      pe_in_vld    <= 1'b0;
      pe_in_last   <= 1'b0;
      pe_picDat    <= '0;
      pe_weightDat <= '0;
    end else begin
      state      <= nxt;
      rd_q       <= pic_rd_en;
      last_q     <= pic_rd_en & fetch_last;
      pe_in_vld  <= rd_q;
      pe_in_last <= last_q;
      if (rd_q) begin
        pe_picDat    <= pic_rdata;
        pe_weightDat <= wgt_rdata;
      end
      if (state == IDLE && start) begin
        w_q   <= img_w;
        h_q   <= img_h;
        err_q <= 1'b0;
      end
      if (state == CHECK && bad) err_q <= 1'b1;
      if (state == WAIT && pe_valid) res_q <= cap;
    end
  end
endmodule
